vproc_xreg_reorder: RTL
=======================

Name: vproc_xreg_reorder

Overview:
- In-order result queue for vector instructions that write a scalar x register (vmv.x.s, vcpop.m, vfirst.m, reductions to scalar).
- Dispatch allocates one entry per instruction in program order. Execution units complete out of order by instruction ID.
- The block sits directly upstream of the result stage. It drives the result_xreg valid/ready stream in allocation order, so scalar results return to the host core oldest-first.

Parameters:
- XIF_ID_W, 3, width in bits of instruction IDs.
- DEPTH, 4, number of in-flight entries; power of two, >= 2.
- DONT_CARE_ZERO, 1'b0, drive don't-care outputs to '0 instead of 'x.

Ports:
- clk_i  in  1  clock
- async_rst_ni  in  1  reset, asynchronous, active-low
- sync_rst_ni  in  1  synchronous reset, active-low
- flush_i  in  1  discard all entries
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_ready_o  out  1  entry available
- alloc_id_i  in  XIF_ID_W  instruction ID
- alloc_addr_i  in  5  destination x register
- wb_valid_i  in  1  unit completes an instruction (no ready; always accepted)
- wb_id_i  in  XIF_ID_W  completing instruction ID
- wb_data_i  in  32  scalar result
- result_xreg_valid_o  out  1  head result valid
- result_xreg_ready_i  in  1  result stage accepts
- result_xreg_id_o  out  XIF_ID_W  head ID
- result_xreg_addr_o  out  5  head rd
- result_xreg_data_o  out  32  head data
- empty_o  out  1  no entries in flight

Behaviour:
- Storage: circular buffer of DEPTH entries. Each entry has vld and done flags (async/sync reset to 0) and id, addr, data fields (no reset).
- Pointers: rd_ptr and wr_ptr, log2(DEPTH) bits, wrap modulo DEPTH. cnt is log2(DEPTH)+1 bits.
- Reset (async or sync): vld/done cleared, pointers and cnt = 0. Outputs after reset: alloc_ready_o=1, result_xreg_valid_o=0, empty_o=1.
- alloc_ready_o = (cnt != DEPTH). There is no full bypass: when full, alloc_ready_o stays 0 even if a pop happens in the same cycle.
- Alloc handshake (alloc_valid_i & alloc_ready_o):
  - Writes entry[wr_ptr]: vld=1, done=0, id, addr.
  - Increments wr_ptr.
- Writeback: every entry with vld & ~done & id==wb_id_i sets done=1 and stores data=wb_data_i.
- Writeback in the same cycle as alloc with alloc_id_i==wb_id_i: the new entry is written with done=1 and data=wb_data_i.
- Writeback matching no entry: ignored, state unchanged (SVA flags it).
- Output:
  - result_xreg_valid_o = entry[rd_ptr].vld & entry[rd_ptr].done.
  - id/addr/data are read combinationally from entry[rd_ptr].
  - When valid_o=0, id/addr/data are '0 if DONT_CARE_ZERO, else 'x.
- Latency: writeback to the head entry in cycle N gives valid_o=1 in cycle N+1. No combinational path from wb_* or alloc_* to result_xreg_*.
- Pop (valid_o & ready_i): clears entry[rd_ptr].vld and done, increments rd_ptr.
- Stability: while valid_o & ~ready_i, valid_o and id/addr/data hold unchanged. Done entries are immutable; later writebacks cannot alter the head.
- cnt update: +1 on alloc only, -1 on pop only, unchanged on both. empty_o = (cnt == 0).
- Out-of-order completion: younger done entries wait behind an undone head. valid_o stays 0 until the head completes.
- flush_i (synchronous):
  - Clears all vld/done, pointers and cnt in the next cycle.
  - Has priority over alloc, writeback and pop in the same cycle; an alloc handshake occurring alongside flush_i is discarded.
  - result_xreg_valid_o is 0 from the cycle after flush_i.
- Upstream guarantee (SVA): an ID is not allocated while an entry with that ID is vld.
- SVA checks: cnt <= DEPTH; no pop when empty; outputs stable under backpressure.

Test Plan:
- In-order: alloc IDs 1,2,3 (rd x5,x6,x7); wb 1,2,3 with data 0xA,0xB,0xC; ready=1 -> outputs (1,x5,0xA),(2,x6,0xB),(3,x7,0xC), each one cycle after its wb; empty_o=1 afterwards.
- Out-of-order: alloc 4,5,6; wb 6 then 5 then 4 -> valid_o stays 0 until wb 4, then 4,5,6 are emitted in consecutive cycles.
- Full/backpressure: DEPTH=4, allocate 4 entries -> alloc_ready_o=0. Complete the head with ready_i=0 for 3 cycles -> valid_o=1 and id/data constant. Raise ready -> pop, and alloc_ready_o=1 next cycle.
- Same-cycle alloc+wb: alloc ID 2 and wb ID 2 data 0xDEAD in cycle N into an empty queue -> valid_o=1 with data 0xDEAD in cycle N+1.
- Wrap-around: 10 sequential alloc/wb/pop rounds with DEPTH=4 -> pointers wrap, results are emitted in order, cnt returns to 0.
- Flush: 3 entries in flight, head done and ready_i=0, flush_i together with an alloc -> next cycle valid_o=0, empty_o=1, alloc_ready_o=1; a later wb to a flushed ID is ignored.

Source files
------------

// File: rtl/vproc_xreg_reorder.sv
// In-order result queue for vector instructions that write a scalar x register.
// Dispatch allocates entries in program order, execution units complete them
// out of order by instruction ID, and results leave oldest-first.
module vproc_xreg_reorder #(
  parameter int unsigned XIF_ID_W       = 3,
  parameter int unsigned DEPTH          = 4,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                sync_rst_ni,
  input  logic                flush_i,

  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  input  logic [XIF_ID_W-1:0] alloc_id_i,
  input  logic [4:0]          alloc_addr_i,

  input  logic                wb_valid_i,
  input  logic [XIF_ID_W-1:0] wb_id_i,
  input  logic [31:0]         wb_data_i,

  output logic                result_xreg_valid_o,
  input  logic                result_xreg_ready_i,
  output logic [XIF_ID_W-1:0] result_xreg_id_o,
  output logic [4:0]          result_xreg_addr_o,
  output logic [31:0]         result_xreg_data_o,

  output logic                empty_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]    vld_q, done_q;
  logic [XIF_ID_W-1:0] id_q   [DEPTH];
  logic [4:0]          addr_q [DEPTH];
  logic [31:0]         data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   cnt_q;

  logic             alloc_hs, alloc_wb_hit, head_valid, pop;
  logic [DEPTH-1:0] wb_hit, alloc_id_busy;

  // Match the writeback against pending entries; done entries are never rewritten
  always_comb begin
    wb_hit        = '0;
    alloc_id_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wb_hit[i]        = wb_valid_i & vld_q[i] & ~done_q[i] & (id_q[i] == wb_id_i);
      alloc_id_busy[i] = vld_q[i] & (id_q[i] == alloc_id_i);
    end
  end

  // No full bypass: a pop in the same cycle does not free a slot early
  assign alloc_ready_o = (cnt_q != CNT_FULL);
  assign alloc_hs      = alloc_valid_i & alloc_ready_o;
  assign alloc_wb_hit  = wb_valid_i & (alloc_id_i == wb_id_i);
  assign head_valid    = vld_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign pop           = head_valid & result_xreg_ready_i;
  assign empty_o       = (cnt_q == '0);

  // Entry flags, pointers and occupancy; flush and sync reset override everything
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      vld_q    <= '0;
      done_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (!sync_rst_ni || flush_i) begin
      vld_q    <= '0;
      done_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= done_q | wb_hit;
      if (pop) begin
        vld_q[rd_ptr_q]  <= 1'b0;
        done_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PTR_ONE;
      end
      if (alloc_hs) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        done_q[wr_ptr_q] <= alloc_wb_hit;
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      case ({alloc_hs, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload fields carry no reset; the flags above decide whether they are meaningful
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit[i]) begin
        data_q[i] <= wb_data_i;
      end
    end
    if (alloc_hs) begin
      id_q[wr_ptr_q]   <= alloc_id_i;
      addr_q[wr_ptr_q] <= alloc_addr_i;
      if (alloc_wb_hit) begin
        data_q[wr_ptr_q] <= wb_data_i;
      end
    end
  end

  // Head entry drives the result stream purely from registered state
  always_comb begin
    result_xreg_valid_o = head_valid;
    if (head_valid) begin
      result_xreg_id_o   = id_q[rd_ptr_q];
      result_xreg_addr_o = addr_q[rd_ptr_q];
      result_xreg_data_o = data_q[rd_ptr_q];
    end else if (DONT_CARE_ZERO) begin
      result_xreg_id_o   = '0;
      result_xreg_addr_o = '0;
      result_xreg_data_o = '0;
    end else begin
      result_xreg_id_o   = 'x;
      result_xreg_addr_o = 'x;
      result_xreg_data_o = 'x;
    end
  end

  assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    cnt_q <= CNT_FULL);

  assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    pop |-> (cnt_q != '0));

  assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    (alloc_hs & sync_rst_ni & ~flush_i) |-> ~(|alloc_id_busy));

  assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    (result_xreg_valid_o & ~result_xreg_ready_i & ~flush_i & sync_rst_ni)
    |=> (result_xreg_valid_o && $stable(result_xreg_id_o) &&
         $stable(result_xreg_addr_o) && $stable(result_xreg_data_o)));

  // Late completions of flushed instructions are legal, so these are recorded, not fatal
  cover property (@(posedge clk_i) disable iff (!async_rst_ni)
    wb_valid_i & sync_rst_ni & ~flush_i & ~(|wb_hit) & ~(alloc_hs & alloc_wb_hit));

endmodule
